pcie_trans_multi: RTL and testbench

Parametrised next-generation PCIe transaction-path block: main FIFO → NUM_VC virtual-channel FIFOs → arbiter → NUM_DEST destination FIFOs, with a control FSM (init/idle/active/error) and programmable almost-full thresholds.
Generalises the fixed 2-VC/2-destination path to arbitrary power-of-two channel and destination counts and configurable depths.
Adds credit-safe backpressure at every stage and sticky error detection.

---
 rtl/pcie_trans_pkg.sv | 28 ++
 rtl/sync_fifo_fwft.sv | 56 +++++
 rtl/pcie_trans_multi.sv | 183 ++++++++++++++++++
 tb/tb_pcie_trans_multi.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_trans_pkg.sv
// rtl/pcie_trans_pkg.sv - FSM state encoding, clog2 and routing-field offset helpers
package pcie_trans_pkg;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    INIT   = 3'd1,
    IDLE   = 3'd2,
    ACTIVE = 3'd3,
    ERROR  = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // VC field occupies the MSBs; the destination field sits directly below it
  function automatic int vc_lsb(input int data_w, input int num_vc);
    return data_w - clog2(num_vc);
  endfunction

  function automatic int dest_lsb(input int data_w, input int num_vc, input int num_dest);
    return data_w - clog2(num_vc) - clog2(num_dest);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with registered occupancy count
module sync_fifo_fwft
  import pcie_trans_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    pop,
  input  logic [clog2(DEPTH)-1:0] umbral,
  output logic [DATA_W-1:0]       data,
  output logic [clog2(DEPTH):0]   count,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    err
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= (DEPTH_C - {1'b0, umbral}));
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign err         = (push && full) || (pop && empty);
  // Head reads as zero while empty so the output never exposes stale storage
  assign data        = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pcie_trans_multi.sv
// rtl/pcie_trans_multi.sv - main FIFO -> VC FIFOs -> arbiter -> destination FIFOs with control FSM
// PCIE_RR_ARB_EN selects a round-robin stage-2 arbiter instead of strict lowest-index priority.
module pcie_trans_multi
  import pcie_trans_pkg::*;
#(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int MF_DEPTH = 4,
  parameter int VC_DEPTH = 16,
  parameter int D_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [clog2(MF_DEPTH)-1:0] umbral_mf,
  input  logic [clog2(VC_DEPTH)-1:0] umbral_vc,
  input  logic [clog2(D_DEPTH)-1:0]  umbral_d,
  input  logic                       push,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [NUM_DEST-1:0]        pop,
  output logic [NUM_DEST*DATA_W-1:0] data_out,
  output logic [NUM_DEST-1:0]        empty_out,
  output logic                       pause_out,
  output logic                       active_out,
  output logic                       idle_out,
  output logic                       error_out
);

  localparam int VB     = clog2(NUM_VC);
  localparam int DB     = clog2(NUM_DEST);
  localparam int MA     = clog2(MF_DEPTH);
  localparam int VA     = clog2(VC_DEPTH);
  localparam int DA     = clog2(D_DEPTH);
  localparam int VC_LSB = vc_lsb(DATA_W, NUM_VC);
  localparam int D_LSB  = dest_lsb(DATA_W, NUM_VC, NUM_DEST);

  state_t state, state_nxt;
  logic [MA-1:0] th_mf;
  logic [VA-1:0] th_vc;
  logic [DA-1:0] th_d;
  logic          run;
  logic          err_any;
  logic          any_busy;

  logic [DATA_W-1:0] mf_data;
  logic [MA:0]       mf_count;
  logic              mf_empty, mf_full, mf_af, mf_err, mf_pop;
  logic [VB-1:0]     mf_vc;

  logic [DATA_W-1:0] vc_data  [NUM_VC];
  logic [VA:0]       vc_count [NUM_VC];
  logic [DB-1:0]     vc_dest  [NUM_VC];
  logic [NUM_VC-1:0] vc_empty, vc_full, vc_af, vc_err, vc_push, vc_pop, elig;

  logic [DATA_W-1:0]   d_data  [NUM_DEST];
  logic [DA:0]         d_count [NUM_DEST];
  logic [NUM_DEST-1:0] d_empty, d_full, d_af, d_err, d_push;

  logic              gnt_vld;
  logic [VB-1:0]     gnt_idx;
  logic [VB-1:0]     cand;
  logic [DB-1:0]     gnt_dest;
  logic [DATA_W-1:0] gnt_data;
  logic              unused_flags;

  assign run          = (state == IDLE) || (state == ACTIVE) || (state == ERROR);
  assign unused_flags = ^{mf_full, vc_af, d_af};

  sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(MF_DEPTH)) u_mf (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(mf_pop),
    .umbral(th_mf), .data(mf_data), .count(mf_count), .empty(mf_empty),
    .full(mf_full), .almost_full(mf_af), .err(mf_err)
  );

  assign mf_vc     = mf_data[VC_LSB +: VB];
  assign mf_pop    = run && !mf_empty && !vc_full[mf_vc];
  assign pause_out = mf_af;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign vc_push[i] = mf_pop && (mf_vc == VB'(i));
    assign vc_pop[i]  = gnt_vld && (gnt_idx == VB'(i));
    assign vc_dest[i] = vc_data[i][D_LSB +: DB];
    assign elig[i]    = run && !vc_empty[i] && !d_full[vc_dest[i]];

    sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(VC_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(vc_push[i]), .data_in(mf_data), .pop(vc_pop[i]),
      .umbral(th_vc), .data(vc_data[i]), .count(vc_count[i]), .empty(vc_empty[i]),
      .full(vc_full[i]), .almost_full(vc_af[i]), .err(vc_err[i])
    );
  end

`ifdef PCIE_RR_ARB_EN
  logic [VB-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (reset)        rr_ptr <= '0;
    else if (gnt_vld) rr_ptr <= gnt_idx + VB'(1);
  end
`endif

  // Scan candidates in priority order; the first eligible one takes the grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_VC; k++) begin
`ifdef PCIE_RR_ARB_EN
      cand = rr_ptr + VB'(k);
`else
      cand = VB'(k);
`endif
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_dest = vc_dest[gnt_idx];
  assign gnt_data = vc_data[gnt_idx];

  for (genvar j = 0; j < NUM_DEST; j++) begin : g_dest
    assign d_push[j] = gnt_vld && (gnt_dest == DB'(j));

    sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(D_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(d_push[j]), .data_in(gnt_data), .pop(pop[j]),
      .umbral(th_d), .data(d_data[j]), .count(d_count[j]), .empty(d_empty[j]),
      .full(d_full[j]), .almost_full(d_af[j]), .err(d_err[j])
    );

    assign data_out[j*DATA_W +: DATA_W] = d_data[j];
  end

  assign empty_out = d_empty;
  assign err_any   = mf_err || (|vc_err) || (|d_err);

  always_comb begin
    any_busy = (mf_count != '0);
    for (int i = 0; i < NUM_VC; i++)   any_busy = any_busy || (vc_count[i] != '0);
    for (int j = 0; j < NUM_DEST; j++) any_busy = any_busy || (d_count[j] != '0);
  end

  always_comb begin
    state_nxt = state;
    if (err_any) begin
      state_nxt = ERROR;
    end else if (init && (state != ERROR)) begin
      state_nxt = INIT;
    end else begin
      case (state)
        RESET:   state_nxt = INIT;
        INIT:    state_nxt = IDLE;
        IDLE:    if (any_busy)  state_nxt = ACTIVE;
        ACTIVE:  if (!any_busy) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESET;
      active_out <= 1'b0;
      idle_out   <= 1'b0;
      error_out  <= 1'b0;
      th_mf      <= '0;
      th_vc      <= '0;
      th_d       <= '0;
    end else begin
      state      <= state_nxt;
      active_out <= (state_nxt == ACTIVE);
      idle_out   <= (state_nxt == IDLE);
      error_out  <= (state_nxt == ERROR);
      if ((state == INIT) && init) begin
        th_mf <= umbral_mf;
        th_vc <= umbral_vc;
        th_d  <= umbral_d;
      end
    end
  end

endmodule

// File: tb/tb_pcie_trans_multi.sv
// tb/tb_pcie_trans_multi.sv - directed and randomized bench against a queue-based reference model
`timescale 1ns/1ps
module tb_pcie_trans_multi;

  localparam int DW  = 6;
  localparam int NV  = 2;
  localparam int ND  = 2;
  localparam int MFD = 4;
  localparam int VCD = 16;
  localparam int DD  = 4;
`ifdef PCIE_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef enum int {M_RST, M_INIT, M_IDLE, M_ACT, M_ERR} mst_t;

  logic             clk = 1'b0;
  logic             reset, init, push;
  logic [1:0]       umbral_mf;
  logic [3:0]       umbral_vc;
  logic [1:0]       umbral_d;
  logic [DW-1:0]    data_in;
  logic [ND-1:0]    pop;
  logic [ND*DW-1:0] data_out;
  logic [ND-1:0]    empty_out;
  logic             pause_out, active_out, idle_out, error_out;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_mf [$];
  logic [DW-1:0] m_vc [NV][$];
  logic [DW-1:0] m_d  [ND][$];
  mst_t          m_st;
  int            m_thmf;
  int            m_rr;

  pcie_trans_multi #(
    .DATA_W(DW), .NUM_VC(NV), .NUM_DEST(ND),
    .MF_DEPTH(MFD), .VC_DEPTH(VCD), .D_DEPTH(DD)
  ) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_mf(umbral_mf), .umbral_vc(umbral_vc), .umbral_d(umbral_d),
    .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .empty_out(empty_out), .pause_out(pause_out),
    .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  function automatic int vc_of(input logic [DW-1:0] w);
    return int'(w) / (1 << (DW - 1));
  endfunction

  function automatic int dest_of(input logic [DW-1:0] w);
    return (int'(w) / (1 << (DW - 2))) % ND;
  endfunction

  task automatic model_step();
    bit run, err, any, g_vld, s1, mf_was_full;
    int g, v;
    logic [DW-1:0] w;
    if (reset) begin
      m_mf.delete();
      for (int i = 0; i < NV; i++) m_vc[i].delete();
      for (int i = 0; i < ND; i++) m_d[i].delete();
      m_st = M_RST; m_thmf = 0; m_rr = 0;
      return;
    end
    run = (m_st == M_IDLE) || (m_st == M_ACT) || (m_st == M_ERR);
    mf_was_full = (m_mf.size() == MFD);
    err = push && mf_was_full;
    any = (m_mf.size() != 0);
    for (int i = 0; i < ND; i++) begin
      if (pop[i] && m_d[i].size() == 0) err = 1'b1;
      if (m_d[i].size() != 0) any = 1'b1;
    end
    for (int i = 0; i < NV; i++) if (m_vc[i].size() != 0) any = 1'b1;
    g_vld = 1'b0; g = 0;
    if (run) begin
      for (int k = 0; k < NV; k++) begin
        int c;
        c = RR ? (m_rr + k) % NV : k;
        if (!g_vld && m_vc[c].size() != 0 && m_d[dest_of(m_vc[c][0])].size() < DD) begin
          g_vld = 1'b1; g = c;
        end
      end
    end
    s1 = run && (m_mf.size() != 0) && (m_vc[vc_of(m_mf[0])].size() < VCD);
    v  = s1 ? vc_of(m_mf[0]) : 0;
    for (int i = 0; i < ND; i++) if (pop[i] && m_d[i].size() != 0) void'(m_d[i].pop_front());
    if (g_vld) begin
      w = m_vc[g].pop_front();
      m_d[dest_of(w)].push_back(w);
      m_rr = (g + 1) % NV;
    end
    if (s1) m_vc[v].push_back(m_mf.pop_front());
    if (push && !mf_was_full) m_mf.push_back(data_in);
    if (m_st == M_INIT && init) m_thmf = int'(umbral_mf);
    if (err) m_st = M_ERR;
    else if (init && m_st != M_ERR) m_st = M_INIT;
    else if (m_st == M_RST) m_st = M_INIT;
    else if (m_st == M_INIT) m_st = M_IDLE;
    else if (m_st == M_IDLE && any) m_st = M_ACT;
    else if (m_st == M_ACT && !any) m_st = M_IDLE;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("data_out[%0d]", i), 64'(data_out[i*DW +: DW]),
          (m_d[i].size() != 0) ? 64'(m_d[i][0]) : 64'd0);
      chk($sformatf("empty_out[%0d]", i), 64'(empty_out[i]), 64'(m_d[i].size() == 0));
    end
    chk("pause_out",  64'(pause_out),  64'(m_mf.size() >= MFD - m_thmf));
    chk("active_out", 64'(active_out), 64'(m_st == M_ACT));
    chk("idle_out",   64'(idle_out),   64'(m_st == M_IDLE));
    chk("error_out",  64'(error_out),  64'(m_st == M_ERR));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Upstream that honours full/empty as seen by the model, so no error is provoked
  task automatic traffic(input int n, input int p_push, input int p_pop);
    for (int c = 0; c < n; c++) begin
      push    = ($urandom_range(99) < p_push) && (m_mf.size() < MFD);
      data_in = DW'($urandom);
      for (int i = 0; i < ND; i++) pop[i] = ($urandom_range(99) < p_pop) && (m_d[i].size() != 0);
      cycle();
    end
    push = 1'b0;
    pop  = '0;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; push = 1'b0; pop = '0; data_in = '0;
    umbral_mf = '0; umbral_vc = '0; umbral_d = '0;
    m_st = M_RST; m_thmf = 0; m_rr = 0;
    repeat (3) cycle();

    reset = 1'b0; init = 1'b1; umbral_mf = 2'd1; umbral_vc = 4'd2; umbral_d = 2'd1;
    repeat (2) cycle();
    init = 1'b0; umbral_mf = 2'd3;
    repeat (2) cycle();

    push = 1'b1; data_in = 6'b01_0101;
    cycle();
    push = 1'b0;
    repeat (2) cycle();
    pop = 2'b10;
    cycle();
    pop = '0;
    repeat (3) cycle();

    for (int c = 0; c < 12; c++) begin
      push = (m_mf.size() < MFD); data_in = DW'(c % 16);
      cycle();
    end
    push = 1'b0;
    traffic(30, 0, 100);

    for (int c = 0; c < 16; c++) begin
      push = (m_mf.size() < MFD);
      data_in = (c % 2 != 0) ? (6'h30 | DW'(c % 16)) : DW'(c % 16);
      cycle();
    end
    push = 1'b0;
    traffic(40, 0, 100);

    traffic(300, 60, 50);

    push = 1'b1; pop = '0; data_in = 6'h3a;
    repeat (32) cycle();
    push = 1'b0;
    init = 1'b1;
    repeat (3) cycle();
    init = 1'b0;
    traffic(40, 60, 50);

    traffic(5, 80, 30);
    reset = 1'b1; push = 1'b1; pop = 2'b11; data_in = 6'h15;
    cycle();
    reset = 1'b0; push = 1'b0; pop = '0;
    cycle();

    umbral_mf = 2'($urandom); umbral_vc = 4'($urandom); umbral_d = 2'($urandom);
    init = 1'b1;
    repeat (2) cycle();
    init = 1'b0;
    traffic(200, 70, 40);
    traffic(60, 0, 100);

    pop = 2'b01;
    cycle();
    pop = '0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
